// File: rtl/fadd_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_sched_pkg
//  Description : Shared constants and helpers for the FP32 adder scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package fadd_sched_pkg;

    localparam int FP_W            = 32;
    localparam int N_REQ_DEFAULT   = 4;
    localparam int MAX_OUT_DEFAULT = 8;
    localparam int TAG_W           = $clog2(N_REQ_DEFAULT);

    // Index width that never collapses to zero bits for a single entry.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fadd_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_tag_fifo
//  Description : Synchronous FIFO of requester tags with wrap-around pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
module fadd_tag_fifo
    import fadd_sched_pkg::*;
#(
    parameter int DEPTH = MAX_OUT_DEFAULT,
    parameter int WIDTH = TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_addr_w = clog2_min1(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [c_addr_w:0]  r_wr_ptr;
    logic [c_addr_w:0]  r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                        (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fadd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_scheduler
//  Description : Round-robin, credit-limited sharing of one pipelined FP32 adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module fadd_scheduler
    import fadd_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*FP_W-1:0] req_op_1,
    input  logic [N_REQ*FP_W-1:0] req_op_2,
    output logic                  add_en,
    output logic [FP_W-1:0]       add_op_1,
    output logic [FP_W-1:0]       add_op_2,
    input  logic [FP_W-1:0]       add_res,
    input  logic                  add_val,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_res,
    output logic                  busy,
    output logic                  orphan_err
);
    localparam int c_tag_w = clog2_min1(N_REQ);
    localparam int c_cnt_w = $clog2(MAX_OUT + 1);

    logic [c_tag_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_outstanding;
    logic               r_add_en;
    logic [FP_W-1:0]    r_op1;
    logic [FP_W-1:0]    r_op2;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [FP_W-1:0]    r_rsp_res;
    logic               r_orphan;

    logic               w_credit;
    logic               w_grant;
    logic [c_tag_w-1:0] w_grant_idx;
    logic [N_REQ-1:0]   w_ready;
    logic               w_pop;
    logic [c_tag_w-1:0] w_fifo_tag;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FP_W-1:0]    w_op1_arr [N_REQ];
    logic [FP_W-1:0]    w_op2_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_op1_arr[g] = req_op_1[g*FP_W +: FP_W];
        assign w_op2_arr[g] = req_op_2[g*FP_W +: FP_W];
    end

    // Credit uses the registered count, so a pop frees a slot only next cycle.
    assign w_credit = !reset && !w_fifo_full && (r_outstanding != c_cnt_w'(MAX_OUT));
    assign w_pop    = add_val && !w_fifo_empty;

    always_comb begin : p_arbiter
        int idx;
        w_ready     = '0;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(r_ptr) + k) % N_REQ;
            if (w_credit && !w_grant && req_valid[c_tag_w'(idx)]) begin
                w_grant     = 1'b1;
                w_grant_idx = c_tag_w'(idx);
            end
        end
        if (w_grant) w_ready[w_grant_idx] = 1'b1;
    end

    fadd_tag_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (c_tag_w)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_grant),
        .i_push_data (w_grant_idx),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_tag),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= '0;
            r_outstanding <= '0;
            r_add_en      <= 1'b0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_rsp_valid   <= '0;
            r_rsp_res     <= '0;
            r_orphan      <= 1'b0;
        end else begin
            r_add_en    <= w_grant;
            r_rsp_valid <= '0;
            if (w_grant) begin
                r_op1 <= w_op1_arr[w_grant_idx];
                r_op2 <= w_op2_arr[w_grant_idx];
                r_ptr <= (w_grant_idx == c_tag_w'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (w_pop) begin
                r_rsp_valid <= N_REQ'(1) << w_fifo_tag;
                r_rsp_res   <= add_res;
            end
            // A result with no tag to own it is dropped and flagged.
            if (add_val && w_fifo_empty) r_orphan <= 1'b1;
            case ({w_grant, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign add_en     = r_add_en;
    assign add_op_1   = r_op1;
    assign add_op_2   = r_op2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_res    = r_rsp_res;
    assign busy       = (r_outstanding != '0);
    assign orphan_err = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_fadd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fadd_scheduler
//  Description : Self-checking bench: stub in-order adder plus reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_scheduler;
    localparam int N = 4;
    localparam int M = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_op_1;
    logic [N*32-1:0] req_op_2;
    logic           add_en;
    logic [31:0]    add_op_1;
    logic [31:0]    add_op_2;
    logic [31:0]    add_res;
    logic           add_val;
    logic [N-1:0]   rsp_valid;
    logic [31:0]    rsp_res;
    logic           busy;
    logic           orphan_err;

    fadd_scheduler #(.N_REQ(N), .MAX_OUT(M)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op_1   (req_op_1),
        .req_op_2   (req_op_2),
        .add_en     (add_en),
        .add_op_1   (add_op_1),
        .add_op_2   (add_op_2),
        .add_res    (add_res),
        .add_val    (add_val),
        .rsp_valid  (rsp_valid),
        .rsp_res    (rsp_res),
        .busy       (busy),
        .orphan_err (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int lat     = 4;

    // Stub adder pipeline: results come back in issue order after lat cycles.
    int          due_q[$];
    logic [31:0] res_q[$];

    // Reference model: pointer, queue of owner tags, expected outputs.
    int          m_ptr = 0;
    int          m_tags[$];
    int          m_grant;
    logic [N-1:0] exp_ready, exp_rsp_valid;
    logic         exp_add_en, exp_orphan;
    logic [31:0]  exp_op1, exp_op2, exp_rsp_res;

    logic [N-1:0] obs_ready, obs_rsp_valid;
    logic         obs_add_en, obs_busy, obs_orphan;
    logic [31:0]  obs_op1, obs_op2, obs_rsp_res;

    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3FC0_0000 && b == 32'h4010_0000) return 32'h4070_0000;
        return a + b + 32'h1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_op_1[i*32 +: 32] = $urandom;
            req_op_2[i*32 +: 32] = $urandom;
        end
    endtask

    // One clock: drive adder return, predict, clock, then sample outputs.
    task automatic advance();
        add_val = 1'b0;
        add_res = $urandom;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            add_val = 1'b1;
            add_res = res_q[0];
            due_q.delete(0);
            res_q.delete(0);
        end
        #1;
        obs_ready = req_ready;
        exp_ready = '0;
        m_grant   = -1;
        if (!reset && m_tags.size() < M) begin
            for (int k = 0; k < N; k++) begin
                if (m_grant < 0 && req_valid[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
            end
        end
        if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
        if (reset) begin
            m_ptr = 0;
            m_tags.delete();
            exp_add_en = 1'b0; exp_op1 = '0; exp_op2 = '0;
            exp_rsp_valid = '0; exp_rsp_res = '0; exp_orphan = 1'b0;
        end else begin
            exp_add_en    = (m_grant >= 0);
            exp_rsp_valid = '0;
            if (add_val) begin
                if (m_tags.size() > 0) begin
                    exp_rsp_valid[m_tags[0]] = 1'b1;
                    exp_rsp_res = add_res;
                    m_tags.delete(0);
                end else begin
                    exp_orphan = 1'b1;
                end
            end
            if (m_grant >= 0) begin
                exp_op1 = req_op_1[m_grant*32 +: 32];
                exp_op2 = req_op_2[m_grant*32 +: 32];
                m_tags.push_back(m_grant);
                m_ptr = (m_grant + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        obs_add_en = add_en;  obs_op1 = add_op_1;  obs_op2 = add_op_2;
        obs_rsp_valid = rsp_valid;  obs_rsp_res = rsp_res;
        obs_busy = busy;  obs_orphan = orphan_err;
        if (add_en) begin
            due_q.push_back(cyc + lat);
            res_q.push_back(fake_add(add_op_1, add_op_2));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        advance();
        reset = 1'b0;
        due_q.delete();
        res_q.delete();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (t < 200 && (due_q.size() > 0 || m_tags.size() > 0 || obs_rsp_valid != 0)) begin
            advance();
            n_total++;
            if (obs_rsp_valid !== exp_rsp_valid || obs_rsp_res !== exp_rsp_res)
                $display("FAIL drain_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, obs_rsp_valid, obs_rsp_res, exp_rsp_valid, exp_rsp_res);
            else n_pass++;
            t++;
        end
        n_total++;
        if (t >= 200) $display("FAIL drain_timeout got=%0d pending exp=0", due_q.size() + m_tags.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        rand_ops();
        advance();
        advance();
        n_total++; if (obs_ready !== 4'b0) $display("FAIL reset_ready got=%b exp=0000", obs_ready); else n_pass++;
        n_total++; if (obs_add_en !== 1'b0) $display("FAIL reset_add_en got=%b exp=0", obs_add_en); else n_pass++;
        n_total++; if (obs_op1 !== 32'h0 || obs_op2 !== 32'h0) $display("FAIL reset_ops got=%h/%h exp=0/0", obs_op1, obs_op2); else n_pass++;
        n_total++; if (obs_rsp_valid !== 4'b0 || obs_rsp_res !== 32'h0) $display("FAIL reset_rsp got=%b/%h exp=0/0", obs_rsp_valid, obs_rsp_res); else n_pass++;
        n_total++; if (obs_busy !== 1'b0 || obs_orphan !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", obs_busy, obs_orphan); else n_pass++;
        reset = 1'b0;
        req_valid = '0;
        due_q.delete();
        res_q.delete();
    endtask

    task automatic test_single();
        int c_en, t;
        do_reset();
        lat = 3;
        rand_ops();
        req_op_1[64 +: 32] = 32'h3FC0_0000;
        req_op_2[64 +: 32] = 32'h4010_0000;
        req_valid = 4'b0100;
        advance();
        req_valid = '0;
        c_en = cyc;
        n_total++; if (obs_ready !== 4'b0100) $display("FAIL single_ready got=%b exp=0100", obs_ready); else n_pass++;
        n_total++; if (obs_add_en !== 1'b1) $display("FAIL single_add_en got=%b exp=1", obs_add_en); else n_pass++;
        n_total++; if (obs_op1 !== 32'h3FC0_0000 || obs_op2 !== 32'h4010_0000)
            $display("FAIL single_ops got=%h/%h exp=3fc00000/40100000", obs_op1, obs_op2); else n_pass++;
        n_total++; if (obs_busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", obs_busy); else n_pass++;
        advance();
        n_total++; if (obs_add_en !== 1'b0 || obs_op1 !== 32'h3FC0_0000)
            $display("FAIL single_hold got=%b/%h exp=0/3fc00000", obs_add_en, obs_op1); else n_pass++;
        t = 0;
        while (t < 12 && obs_rsp_valid == 0) begin advance(); t++; end
        n_total++; if (obs_rsp_valid !== 4'b0100 || obs_rsp_res !== 32'h4070_0000)
            $display("FAIL single_rsp got=%b/%h exp=0100/40700000", obs_rsp_valid, obs_rsp_res); else n_pass++;
        n_total++; if (cyc - c_en !== lat + 1) $display("FAIL single_latency got=%0d exp=%0d", cyc - c_en, lat + 1); else n_pass++;
        drain();
        n_total++; if (obs_busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", obs_busy); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want [5];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        lat = 20;
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            advance();
            n_total++; if (obs_ready !== want[i] || obs_ready !== exp_ready)
                $display("FAIL rr_grant step=%0d got=%b exp=%b", i, obs_ready, want[i]); else n_pass++;
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_credit_limit();
        int grants;
        do_reset();
        lat = 20;
        grants = 0;
        req_valid = '1;
        for (int t = 0; t < 60; t++) begin
            rand_ops();
            advance();
            if (obs_ready != 0) grants++;
            if (t == 19) begin
                n_total++; if (grants !== 8) $display("FAIL credit_count got=%0d exp=8", grants); else n_pass++;
            end
            n_total++; if (obs_ready !== exp_ready) $display("FAIL credit_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, exp_ready); else n_pass++;
            n_total++; if (obs_rsp_valid !== exp_rsp_valid || obs_rsp_res !== exp_rsp_res)
                $display("FAIL credit_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, obs_rsp_valid, obs_rsp_res, exp_rsp_valid, exp_rsp_res); else n_pass++;
            n_total++; if (obs_busy !== (m_tags.size() != 0)) $display("FAIL credit_busy cyc=%0d got=%b exp=%b", cyc, obs_busy, m_tags.size() != 0); else n_pass++;
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_tag_order();
        logic [N-1:0] pat [3];
        int want [3];
        int seen[$];
        pat  = '{4'b1000, 4'b0010, 4'b1000};
        want = '{3, 1, 3};
        do_reset();
        lat = 4;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            req_valid = pat[i];
            advance();
            n_total++; if (obs_ready !== pat[i]) $display("FAIL order_grant step=%0d got=%b exp=%b", i, obs_ready, pat[i]); else n_pass++;
        end
        req_valid = '0;
        for (int t = 0; t < 15; t++) begin
            advance();
            for (int i = 0; i < N; i++) if (obs_rsp_valid[i]) seen.push_back(i);
            n_total++; if (obs_rsp_valid !== exp_rsp_valid || obs_rsp_res !== exp_rsp_res)
                $display("FAIL order_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, obs_rsp_valid, obs_rsp_res, exp_rsp_valid, exp_rsp_res); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            n_total++; if (seen.size() <= i || seen[i] !== want[i])
                $display("FAIL order_tag idx=%0d got=%0d exp=%0d", i, (seen.size() > i) ? seen[i] : -1, want[i]); else n_pass++;
        end
        drain();
    endtask

    task automatic run_random(input int cycles, input int density);
        for (int t = 0; t < cycles; t++) begin
            rand_ops();
            req_valid = '0;
            for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(99, 0) < density);
            advance();
            n_total++; if (obs_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, exp_ready); else n_pass++;
            n_total++; if (obs_add_en !== exp_add_en || obs_op1 !== exp_op1 || obs_op2 !== exp_op2)
                $display("FAIL rnd_issue cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, obs_add_en, obs_op1, obs_op2, exp_add_en, exp_op1, exp_op2); else n_pass++;
            n_total++; if (obs_rsp_valid !== exp_rsp_valid || obs_rsp_res !== exp_rsp_res)
                $display("FAIL rnd_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, obs_rsp_valid, obs_rsp_res, exp_rsp_valid, exp_rsp_res); else n_pass++;
            n_total++; if (obs_busy !== (m_tags.size() != 0) || obs_orphan !== exp_orphan)
                $display("FAIL rnd_flags cyc=%0d got=%b%b exp=%b%b", cyc, obs_busy, obs_orphan, m_tags.size() != 0, exp_orphan); else n_pass++;
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_random();
        do_reset();
        lat = $urandom_range(6, 1);
        run_random(300, 40);
    endtask

    task automatic test_simultaneous();
        do_reset();
        lat = 2;
        run_random(80, 90);
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        lat = 10;
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin rand_ops(); advance(); end
        req_valid = '0;
        advance();
        advance();
        n_total++; if (obs_busy !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", obs_busy); else n_pass++;
        reset = 1'b1;
        req_valid = '1;
        advance();
        reset = 1'b0;
        req_valid = '0;
        n_total++; if (obs_ready !== 4'b0) $display("FAIL mid_ready got=%b exp=0000", obs_ready); else n_pass++;
        n_total++; if (obs_add_en !== 1'b0 || obs_op1 !== 32'h0 || obs_op2 !== 32'h0)
            $display("FAIL mid_issue got=%b/%h/%h exp=0/0/0", obs_add_en, obs_op1, obs_op2); else n_pass++;
        n_total++; if (obs_rsp_valid !== 4'b0 || obs_rsp_res !== 32'h0)
            $display("FAIL mid_rsp got=%b/%h exp=0/0", obs_rsp_valid, obs_rsp_res); else n_pass++;
        n_total++; if (obs_busy !== 1'b0 || obs_orphan !== 1'b0) $display("FAIL mid_flags got=%b%b exp=00", obs_busy, obs_orphan); else n_pass++;
        for (int t = 0; t < 12; t++) begin
            advance();
            n_total++; if (obs_rsp_valid !== 4'b0) $display("FAIL stale_rsp cyc=%0d got=%b exp=0000", cyc, obs_rsp_valid); else n_pass++;
        end
        n_total++; if (obs_orphan !== 1'b1) $display("FAIL stale_orphan got=%b exp=1", obs_orphan); else n_pass++;
        n_total++; if (obs_busy !== 1'b0) $display("FAIL stale_busy got=%b exp=0", obs_busy); else n_pass++;
        do_reset();
        n_total++; if (obs_orphan !== 1'b0) $display("FAIL orphan_clear got=%b exp=0", obs_orphan); else n_pass++;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_op_1  = '0;
        req_op_2  = '0;
        add_val   = 1'b0;
        add_res   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_credit_limit();
        test_tag_order();
        test_random();
        test_simultaneous();
        test_reset_mid_flight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=%0d cycles exp=completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fadd_scheduler.md
FADD_SCHEDULER -- requirements
Module: fadd_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one FP32 adder.
REQ-002 SHALL have parameter MAX_OUT, default 8: maximum in-flight adder operations, which is also the tag FIFO depth (power of 2).
REQ-003 SHALL have port clk, input, 1: single clock for all logic, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, N_REQ: per-requester operation request.
REQ-006 SHALL have port req_ready, output, N_REQ: per-requester grant (one-hot or zero).
REQ-007 SHALL have port req_op_1, input, N_REQ*32: packed IEEE-754 single operand A; slice i belongs to requester i.
REQ-008 SHALL have port req_op_2, input, N_REQ*32: packed operand B, same packing as req_op_1.
REQ-009 SHALL have port add_en, output, 1: issue strobe to the adder's en.
REQ-010 SHALL have ports add_op_1 and add_op_2, output, 32 each: operands to the adder.
REQ-011 SHALL have port add_res, input, 32: adder result.
REQ-012 SHALL have port add_val, input, 1: adder result-valid; results return in issue order.
REQ-013 SHALL have port rsp_valid, output, N_REQ: one-cycle result strobe to the owning requester.
REQ-014 SHALL have port rsp_res, output, 32: result data, shared by all requesters and qualified by rsp_valid.
REQ-015 SHALL have port busy, output, 1: high while any operation is in flight.
REQ-016 SHALL have port orphan_err, output, 1: sticky flag, set when add_val arrives with no outstanding tag.

Function
REQ-017 SHALL complete a handshake for requester i on a cycle with req_valid[i] & req_ready[i].
- req_ready is combinational from req_valid, the round-robin pointer and the credit count.
REQ-018 SHALL grant at most one requester per cycle using round-robin arbitration.
- Search starts at the pointer; the pointer moves to (granted+1) mod N_REQ after each grant.
- The pointer holds when there is no grant.
REQ-019 SHALL drive req_ready to all zero when outstanding == MAX_OUT (no credits).
REQ-020 SHALL register operands on grant: next cycle add_en=1, add_op_1/add_op_2 = the granted slices; add_en=0 otherwise.
- add_op_1/add_op_2 hold their last value when add_en=0.
REQ-021 SHALL push the granted requester index into the tag FIFO on the same cycle as the grant.
REQ-022 SHALL pop the tag FIFO on each add_val=1 cycle and register the output: next cycle rsp_valid[tag]=1, rsp_res=add_res.
REQ-023 SHALL keep outstanding as a counter 0..MAX_OUT: +1 on grant, -1 on a valid pop, unchanged when both occur in the same cycle.
REQ-024 SHALL make credit freed by a pop available to a grant no earlier than the following cycle.
REQ-025 SHALL, when add_val=1 and the FIFO is empty: drop the result, assert no rsp_valid, and set orphan_err until reset.
REQ-026 SHALL drive busy = (outstanding != 0).
REQ-027 SHALL add 2 cycles of scheduler latency beyond adder latency: grant to add_en is 1 cycle; add_val to rsp_valid is 1 cycle.
REQ-028 SHALL NOT interpret operand values; NaN, Inf and denormal operands pass through unchanged.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, clear: req_ready=0, add_en=0, add_op_1=add_op_2=0, rsp_valid=0, rsp_res=0, pointer=0, outstanding=0, FIFO empty, orphan_err=0, busy=0.
REQ-030 SHALL treat reset mid-operation as dropping all in-flight tags; add_val pulses arriving after reset for pre-reset ops are orphans per REQ-025.

Structure
REQ-031 SHALL place FP_W=32, the N_REQ/MAX_OUT defaults and the tag width $clog2(N_REQ) in package fadd_sched_pkg.
REQ-032 SHALL implement the tag FIFO as sub-module fadd_tag_fifo (sync push/pop, full/empty, wrap-around pointers).
- A simultaneous push and pop when empty is not legal: issue precedes return by at least 1 cycle.

Verification
REQ-033 SHALL pass a single request: req 2 valid with 1.5 + 2.25 -> add_en 1 cycle later with ops 0x3FC00000/0x40100000; after add_val, rsp_valid[2]=1 with rsp_res=0x40700000.
REQ-034 SHALL pass a round-robin test: all 4 requesters held valid -> grants in order 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL pass a credit-limit test: adder latency 20, MAX_OUT=8, continuous requests -> exactly 8 grants, then req_ready=0 until the first rsp, then 1 grant per return.
REQ-036 SHALL pass a tag-ordering test: interleaved grants 3,1,3 -> rsp_valid order 3,1,3 with matching results; FIFO pointer wrap covered by more than 8 sequential ops.
REQ-037 SHALL pass a reset-mid-flight test: reset with 5 ops outstanding -> outputs zero, busy=0; the next stale add_val sets orphan_err=1 with no rsp_valid.
REQ-038 SHALL pass a simultaneous-event test: a grant and an add_val pop in the same cycle -> outstanding unchanged, both transactions correct.
